// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
//   scan_state_t : scanner FSM states
//   key_code_t   : {row_idx[1:0], col_idx[1:0]} position code
//   first_low()  : lowest-index active-low row
//   col_drive()  : one-cold column drive pattern for a column index
//   key_to_hex() : position code -> printed legend (used by the display stage)
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } scan_state_t;

  typedef logic [3:0] key_code_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Scan from the top down so the lowest low row is the one left standing.
  function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] r);
    first_low = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--)
      if (!r[i]) first_low = 2'(i);
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

  // Legend layout:  1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D  with * = E, # = F.
  function automatic logic [3:0] key_to_hex(input key_code_t code);
    case (code)
      4'h0: key_to_hex = 4'h1;
      4'h1: key_to_hex = 4'h2;
      4'h2: key_to_hex = 4'h3;
      4'h3: key_to_hex = 4'hA;
      4'h4: key_to_hex = 4'h4;
      4'h5: key_to_hex = 4'h5;
      4'h6: key_to_hex = 4'h6;
      4'h7: key_to_hex = 4'hB;
      4'h8: key_to_hex = 4'h7;
      4'h9: key_to_hex = 4'h8;
      4'hA: key_to_hex = 4'h9;
      4'hB: key_to_hex = 4'hC;
      4'hC: key_to_hex = 4'hE;
      4'hD: key_to_hex = 4'h0;
      4'hE: key_to_hex = 4'hF;
      default: key_to_hex = 4'hD;
    endcase
  endfunction

endpackage

// File: rtl/debounce_counter.sv
// debounce_counter: saturating up-counter shared by press and release debounce.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   clear : zero the count (wins over inc)
//   inc   : count up by one, holding at LIMIT-1
//   done  : count has reached LIMIT-1
module debounce_counter #(
  parameter int LIMIT = 16,
  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam logic [W-1:0] MAX = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)                 cnt <= '0;
    else if (clear)             cnt <= '0;
    else if (inc && cnt != MAX) cnt <= cnt + W'(1);
  end

  assign done = (cnt == MAX);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning 4x4 keypad controller with press/release
// debounce and a single-cycle strobe per accepted press (no auto-repeat).
//   clk       : clock, rising edge
//   reset     : synchronous, active-low
//   rows      : synchronized row lines, active-low (0 = key closed)
//   cols      : one-cold column drive, bit i low selects column i
//   key       : last accepted key, {row_idx, col_idx}
//   key_valid : one-cycle strobe, key is new on this cycle
// Optional build macro KEYPAD_MULTI_REJECT_EN: treat two or more low rows in
// the driven column as no press, and abort a press debounce if a second row
// drops. Without it the lowest-index low row wins.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output key_code_t key,
  output logic      key_valid
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  scan_state_t   state, state_d;
  logic [1:0]    col_idx, col_d;
  logic [1:0]    row_idx, row_d;
  logic [SW-1:0] settle_cnt, settle_d;
  key_code_t     key_d;
  logic          kv_d;
  logic          deb_clr, deb_inc, deb_done;
  logic          press_seen, row_up, abort;

  // Only the captured row is watched once a press is in flight.
  assign row_up = rows[row_idx];

`ifdef KEYPAD_MULTI_REJECT_EN
  logic [3:0] row_low;
  logic       other_low;
  assign row_low    = ~rows;
  assign press_seen = ($countones(row_low) == 1);
  assign other_low  = |(row_low & ~(4'b0001 << row_idx));
  assign abort      = row_up || other_low;
`else
  assign press_seen = (rows != 4'hF);
  assign abort      = row_up;
`endif

  debounce_counter #(.LIMIT(DEBOUNCE_CYCLES)) u_deb (
    .clk   (clk),
    .reset (reset),
    .clear (deb_clr),
    .inc   (deb_inc),
    .done  (deb_done)
  );

  always_comb begin
    state_d  = state;
    col_d    = col_idx;
    row_d    = row_idx;
    settle_d = settle_cnt;
    key_d    = key;
    kv_d     = 1'b0;
    deb_clr  = 1'b0;
    deb_inc  = 1'b0;
    case (state)
      SCAN: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_d = '0;
          if (press_seen) begin
            row_d   = first_low(rows);
            deb_clr = 1'b1;
            state_d = PRESS_DB;
          end else begin
            col_d = col_idx + 2'd1;
          end
        end else begin
          settle_d = settle_cnt + SW'(1);
        end
      end
      PRESS_DB: begin
        // A bounce on the completing edge wins: abort is checked first.
        if (abort) begin
          col_d    = col_idx + 2'd1;
          settle_d = '0;
          state_d  = SCAN;
        end else if (deb_done) begin
          key_d   = {row_idx, col_idx};
          kv_d    = 1'b1;
          state_d = HELD;
        end else begin
          deb_inc = 1'b1;
        end
      end
      HELD: begin
        if (row_up) begin
          deb_clr = 1'b1;
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (!row_up) begin
          deb_clr = 1'b1;
          state_d = HELD;
        end else if (deb_done) begin
          col_d    = col_idx + 2'd1;
          settle_d = '0;
          state_d  = SCAN;
        end else begin
          deb_inc = 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SCAN;
      col_idx    <= '0;
      row_idx    <= '0;
      settle_cnt <= '0;
      cols       <= 4'b1110;
      key        <= '0;
      key_valid  <= 1'b0;
    end else begin
      state      <= state_d;
      col_idx    <= col_d;
      row_idx    <= row_d;
      settle_cnt <= settle_d;
      cols       <= col_drive(col_d);
      key        <= key_d;
      key_valid  <= kv_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  key_code_t  key;
  logic       key_valid;

  // keymat[row][col] = 1 means that key is physically closed
  logic [3:0][3:0] keymat;

  int total, passed, failed;
  int cyc, nstrobe, strobe_cyc;
  logic [3:0] strobe_key;
  int base, n0, n1, bad;

  keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) rows[r] = ~|(keymat[r] & ~cols);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (key_valid === 1'b1) begin
      nstrobe++;
      strobe_cyc = cyc;
      strobe_key = key;
    end
  endtask

  task automatic wait_cols(input string tag, input logic [3:0] want, input int budget);
    int n;
    n = 0;
    while (cols !== want && n < budget) begin
      step();
      n++;
    end
    check(tag, cols, want);
  endtask

  function automatic logic [3:0] drv(input int i);
    logic [3:0] v;
    v = 4'hF;
    v[i] = 1'b0;
    return v;
  endfunction

  initial begin
    total = 0; passed = 0; failed = 0;
    cyc = 0; nstrobe = 0; strobe_cyc = 0; strobe_key = '0;
    reset = 1'b0;
    keymat = '0;

    // reset held 3 cycles
    repeat (3) step();
    check("rst_cols", cols, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_kv", key_valid, 1'b0);

    // idle scan: 4 cycles per column
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("scan_k%0d", k), cols, drv((k / 4) % 4));
    end
    check("scan_nostrobe", nstrobe, 0);

    // clean press row 2 / col 1, held 40 cycles; col 1 sampled at +8
    keymat[2][1] = 1'b1;
    base = cyc; n0 = nstrobe; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k >= 4 && cols !== 4'b1101) bad++;
    end
    check("press_count", nstrobe - n0, 1);
    check("press_latency", strobe_cyc - base, 24);
    check("press_key", strobe_key, 4'b1001);
    check("press_hex", key_to_hex(strobe_key), 4'h8);
    check("press_cols_frozen", bad, 0);

    // clean release: 16 cycles still held, 17th advances to col 2
    keymat = '0;
    repeat (16) step();
    check("rel_hold", cols, 4'b1101);
    step();
    check("rel_adv", cols, 4'b1011);
    check("rel_key_kept", key, 4'b1001);
    check("rel_nostrobe", nstrobe - n0, 1);

    // bounce on row 0 / col 3: press lands right before the col 3 sample
    repeat (7) step();
    check("bnc_col3", cols, 4'b0111);
    n1 = nstrobe;
    keymat[0][3] = 1'b1;
    repeat (5) step();
    keymat[0][3] = 1'b0;
    step();
    check("bnc_abort_cols", cols, 4'b1110);
    check("bnc_nostrobe", nstrobe - n1, 0);
    keymat[0][3] = 1'b1;
    base = cyc;
    repeat (40) step();
    check("bnc_count", nstrobe - n1, 1);
    check("bnc_latency", strobe_cyc - base, 32);
    check("bnc_key", strobe_key, 4'b0011);
    check("bnc_hex", key_to_hex(strobe_key), 4'hA);

    // release bounce: 8 high, back low, then a clean 16-cycle release
    keymat[0][3] = 1'b0;
    repeat (8) step();
    keymat[0][3] = 1'b1;
    repeat (4) step();
    check("relb_held", cols, 4'b0111);
    keymat[0][3] = 1'b0;
    repeat (16) step();
    check("relb_hold16", cols, 4'b0111);
    step();
    check("relb_adv", cols, 4'b1110);
    check("relb_nostrobe", nstrobe - n1, 1);

    // rows 1 and 3 in col 0 (col 0 sampled at +4)
    keymat[1][0] = 1'b1;
    keymat[3][0] = 1'b1;
    n0 = nstrobe; base = cyc;
    repeat (30) step();
`ifdef KEYPAD_MULTI_REJECT_EN
    check("multi_count", nstrobe - n0, 0);
    check("multi_cols", cols, 4'b0111);
`else
    check("multi_count", nstrobe - n0, 1);
    check("multi_latency", strobe_cyc - base, 20);
    check("multi_key", strobe_key, 4'b0100);
    check("multi_hex", key_to_hex(strobe_key), 4'h4);
    check("multi_cols", cols, 4'b1110);
`endif
    keymat = '0;

    // reset during PRESS_DB with deb_cnt = 10 (col 2 sampled at +4)
    wait_cols("rstp_sync", 4'b1011, 100);
    keymat[0][2] = 1'b1;
    repeat (14) step();
    n0 = nstrobe;
    reset = 1'b0;
    step();
    check("rstp_cols", cols, 4'b1110);
    check("rstp_key", key, 4'h0);
    check("rstp_kv", key_valid, 1'b0);
    repeat (8) step();
    check("rstp_nostrobe", nstrobe - n0, 0);
    keymat = '0;
    reset = 1'b1;
    repeat (3) step();
    check("rstp_scan_c0", cols, 4'b1110);
    step();
    check("rstp_scan_c1", cols, 4'b1101);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Column-scanning 4x4 keypad controller that sits directly downstream of the 4-bit row `sync` double-flop stage. It does the following:
- drives one keypad column low at a time;
- samples the synchronized active-low rows;
- debounces press and release;
- emits exactly one single-cycle `key_valid` pulse with a 4-bit key code per debounced press.

Its output feeds the display/key-history logic.

## Interface
- `SETTLE_CYCLES`, default 4: cycles each column is driven before rows are sampled. Must be ≥ 3, covering the 2-cycle sync latency plus 1.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a press or a release. Hardware builds override it, e.g. 48000.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: reset, synchronous, active-low.
- `rows` input 4: synchronized row lines from `sync`, active-low (0 = key closed).
- `cols` output 4: column drive, one-cold; bit i low selects column i.
- `key` output 4: code of the last accepted key, `{row_idx[1:0], col_idx[1:0]}`.
- `key_valid` output 1: one-cycle strobe; `key` is new on this cycle.

## Operation
- Reset values, applied when `reset`=0 at an edge:
  - `cols`=4'b1110, `key`=4'h0, `key_valid`=0;
  - state SCAN, col_idx=0, settle and debounce counters=0.
- SCAN:
  - Drive the current column; settle_cnt counts 0..SETTLE_CYCLES-1.
  - At settle_cnt==SETTLE_CYCLES-1, sample `rows`:
    - All rows high: advance col_idx (3 wraps to 0), clear settle_cnt.
    - Any row low: capture row_idx (lowest-index low row) and col_idx, clear deb_cnt, go to PRESS_DB. The column is held from this point.
- PRESS_DB:
  - Each cycle the captured row is low, deb_cnt increments.
  - Captured row goes high before the count completes: return to SCAN with the next column and no strobe.
  - deb_cnt reaches DEBOUNCE_CYCLES-1 with the row still low: load `key`, assert `key_valid` for exactly one cycle, go to HELD.
- HELD:
  - Column held; no further strobes, so there is no auto-repeat.
  - Captured row goes high: clear deb_cnt, go to RELEASE_DB.
- RELEASE_DB:
  - deb_cnt increments while the captured row is high.
  - Row goes low again: back to HELD with deb_cnt cleared and no strobe.
  - Count reaches DEBOUNCE_CYCLES-1: go to SCAN, advance the column, clear settle_cnt.
- Other keys pressed while in PRESS_DB, HELD or RELEASE_DB are ignored: only the captured row is watched and the column is held. Those keys are detected on a later scan if still held after release.
- Counter width is $clog2(DEBOUNCE_CYCLES). Counters saturate and never wrap.
- `key` holds its value until the next accepted press.

## Timing
- A full scan revolution with no key pressed takes 4*SETTLE_CYCLES cycles.
- Latency from the rising edge at which `rows` first shows the press in the sampled column to `key_valid`=1 is DEBOUNCE_CYCLES cycles.
- `key` and `key_valid` are registered and change on the same edge.
- `cols` is registered and changes only on SCAN column advance or reset.
- Reset mid-operation, in any state, forces reset values on the next edge. A strobe pending on that edge is suppressed.
- If the press completes on the same edge a bounce occurs, the row value sampled at that edge decides.

## Configuration
- `KEYPAD_MULTI_REJECT_EN` defined:
  - In SCAN, a sample with two or more rows low in the driven column is treated as no press; the column advances.
  - In PRESS_DB, a second row going low aborts to SCAN.
- `KEYPAD_MULTI_REJECT_EN` undefined: the lowest-index low row wins, and other rows are ignored.

## Structure
- `keypad_pkg` holds:
  - the state enum `scan_state_t` (SCAN, PRESS_DB, HELD, RELEASE_DB);
  - the `key_code_t` 4-bit typedef;
  - the function `key_to_hex(key_code_t)` mapping the position code to the printed keypad legend, used by the display stage.
- Sub-module `debounce_counter` is a parameterized saturating counter with `clear`/`inc` inputs and a `done` flag. It is instantiated once and shared by PRESS_DB and RELEASE_DB.

## Test plan
All scenarios use the defaults (SETTLE=4, DEBOUNCE=16).
- Reset: hold `reset`=0 for 3 cycles -> `cols`=1110, `key`=0, `key_valid`=0. After release, `cols` steps 1110→1101→1011→0111→1110, with 4 cycles per step.
- Clean press of row 2 while col 1 is driven, held 40 cycles: `cols` freezes at 1101; `key_valid`=1 for exactly one cycle, 16 cycles after the first low sample, with `key`=4'b1001; no second strobe while held.
- Bounce: row 0 low 5 cycles, high 1 cycle, low 20 cycles during col 3 -> no strobe on the first burst; one strobe with `key`=4'b0011 after the second burst is stable 16 cycles.
- Release bounce: after an accepted press, the row toggles high 8 cycles then low -> no new strobe. Row then held high 16 cycles -> scanning resumes at the next column.
- Two rows (1 and 3) low in col 0:
  - with `KEYPAD_MULTI_REJECT_EN` defined -> no strobe; scanning continues;
  - without the macro -> strobe with `key`=4'b0100.
- Reset asserted during PRESS_DB at deb_cnt=10 -> no strobe, `cols`=1110 on the next edge, state SCAN.
